// File: rtl/alu_operand_b_stage.sv
// Registered ALU B-operand selector for the LC2K execute stage, with a one-entry valid/ready output slot.
// Compile-time option: define ALU_OPB_FWD_EN to enable forwarded-result override of regB and a live fwd_hit.
module alu_operand_b_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OFFSET_W = 16,
  parameter int unsigned NUM_FWD  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sel_regb,
  input  logic [OFFSET_W-1:0]       offset_raw,
  input  logic [DATA_W-1:0]         regb_value,
  input  logic [NUM_FWD-1:0]        fwd_match,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         alu_val_b,
  output logic                      fwd_hit
);

  logic              validQ;
  logic [DATA_W-1:0] dataQ;
  logic              hitQ;

  logic              accept;
  logic [DATA_W-1:0] offsetExt;
  logic [DATA_W-1:0] regbPath;
  logic              regbHit;
  logic [DATA_W-1:0] nextOperand;
  logic              nextHit;

  assign in_ready = !validQ || out_ready;
  assign accept   = in_valid && in_ready;

  // Signed size cast sign-extends, and degenerates cleanly when OFFSET_W == DATA_W.
  assign offsetExt = DATA_W'($signed(offset_raw));

`ifdef ALU_OPB_FWD_EN
  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    regbPath = regb_value;
    regbHit  = 1'b0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_match[i]) begin
        regbPath = fwd_data[i*DATA_W +: DATA_W];
        regbHit  = 1'b1;
      end
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{fwd_match, fwd_data};
  assign regbPath  = regb_value;
  assign regbHit   = 1'b0;
`endif

  assign nextOperand = sel_regb ? regbPath : offsetExt;
  assign nextHit     = sel_regb && regbHit;

  // Flush outranks accept; data only moves on a surviving accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= 1'b0;
      dataQ  <= '0;
      hitQ   <= 1'b0;
    end else begin
      if (flush) begin
        validQ <= 1'b0;
      end else if (accept) begin
        validQ <= 1'b1;
      end else if (out_ready) begin
        validQ <= 1'b0;
      end
      if (accept && !flush) begin
        dataQ <= nextOperand;
        hitQ  <= nextHit;
      end
    end
  end

  assign out_valid = validQ;
  assign alu_val_b = dataQ;
  assign fwd_hit   = hitQ;

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Self-checking bench for alu_operand_b_stage: directed scenarios plus randomized traffic against a reference model.
module tb_alu_operand_b_stage;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned NUM_FWD  = 2;
`ifdef ALU_OPB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      sel_regb = 1'b0;
  logic [OFFSET_W-1:0]       offset_raw = '0;
  logic [DATA_W-1:0]         regb_value = '0;
  logic [NUM_FWD-1:0]        fwd_match = '0;
  logic [NUM_FWD*DATA_W-1:0] fwd_data = '0;
  logic                      flush = 1'b0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [DATA_W-1:0]         alu_val_b;
  logic                      fwd_hit;

  int passCnt = 0;
  int totalCnt = 0;
  bit cmpEn = 1'b0;

  alu_operand_b_stage #(.DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel_regb(sel_regb), .offset_raw(offset_raw), .regb_value(regb_value),
    .fwd_match(fwd_match), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_val_b(alu_val_b), .fwd_hit(fwd_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference operand: offset read as a signed 16-bit number, or first matching forward source.
  function automatic logic [DATA_W-1:0] refOperand(input bit sel, input logic [OFFSET_W-1:0] off,
      input logic [DATA_W-1:0] rb, input logic [NUM_FWD-1:0] m, input logic [NUM_FWD*DATA_W-1:0] d);
    int sval;
    if (!sel) begin
      sval = int'(off);
      if (sval >= 32768) sval = sval - 65536;
      return DATA_W'(sval);
    end
    if (FWD) begin
      for (int i = 0; i < int'(NUM_FWD); i++)
        if (m[i]) return d[i*DATA_W +: DATA_W];
    end
    return rb;
  endfunction

  function automatic bit refHit(input bit sel, input logic [NUM_FWD-1:0] m);
    return FWD && sel && (m != '0);
  endfunction

  bit              mValid = 1'b0;
  logic [DATA_W-1:0] mData = '0;
  bit              mHit = 1'b0;

  // Model: slot is free when empty or being drained; flush kills the slot and any accept.
  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    if (!rst_n) begin
      mValid = 1'b0; mData = '0; mHit = 1'b0;
    end else begin
      acc = in_valid && (!mValid || out_ready);
      if (flush) mValid = 1'b0;
      else if (acc) begin
        mValid = 1'b1;
        mData  = refOperand(sel_regb, offset_raw, regb_value, fwd_match, fwd_data);
        mHit   = refHit(sel_regb, fwd_match);
      end else if (out_ready) mValid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmpEn && rst_n) begin
      check("cyc_out_valid", 64'(out_valid), 64'(mValid));
      check("cyc_in_ready", 64'(in_ready), 64'(!mValid || out_ready));
      check("cyc_alu_val_b", 64'(alu_val_b), 64'(mData));
      check("cyc_fwd_hit", 64'(fwd_hit), 64'(mHit));
    end
  end

  task automatic setIn(input bit v, input bit sel, input logic [15:0] off, input logic [31:0] rb,
      input logic [1:0] m, input logic [31:0] d0, input logic [31:0] d1, input bit rdy, input bit fl);
    in_valid = v; sel_regb = sel; offset_raw = off; regb_value = rb;
    fwd_match = m; fwd_data = {d1, d0}; out_ready = rdy; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_val_b", 64'(alu_val_b), 64'd0);
    check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    cmpEn = 1'b1;

    // Model pins
    check("pin_sext_neg", 64'(refOperand(1'b0, 16'hFFFE, 32'h0, 2'b00, '0)), 64'hFFFF_FFFE);
    check("pin_sext_pos", 64'(refOperand(1'b0, 16'h7FFF, 32'h0, 2'b00, '0)), 64'h0000_7FFF);

    // 1: negative offset
    setIn(1, 0, 16'hFFFE, 32'h0, 2'b00, 0, 0, 1, 0);
    step();
    check("t1_alu_val_b", 64'(alu_val_b), 64'hFFFF_FFFE);
    check("t1_out_valid", 64'(out_valid), 64'd1);

    // 2: single forward match on source 1
    setIn(1, 1, 16'h0, 32'h1234, 2'b10, 32'hDEAD, 32'hAAAA, 1, 0);
    step();
    check("t2_alu_val_b", 64'(alu_val_b), FWD ? 64'hAAAA : 64'h1234);
    check("t2_fwd_hit", 64'(fwd_hit), FWD ? 64'd1 : 64'd0);

    // 3: both match, youngest wins
    setIn(1, 1, 16'h0, 32'h3, 2'b11, 32'd5, 32'd9, 1, 0);
    step();
    check("t3_alu_val_b", 64'(alu_val_b), FWD ? 64'd5 : 64'd3);
    // fwd_match ignored with offset select
    setIn(1, 0, 16'h0042, 32'h3, 2'b11, 32'd5, 32'd9, 1, 0);
    step();
    check("t3b_alu_val_b", 64'(alu_val_b), 64'h42);
    check("t3b_fwd_hit", 64'(fwd_hit), 64'd0);

    // 4: hold then pass-through with no bubble
    setIn(0, 0, 16'h0, 32'h0, 2'b00, 0, 0, 1, 0);
    step();
    check("t4_drained", 64'(out_valid), 64'd0);
    check("t4_drain_keeps", 64'(alu_val_b), 64'h42);
    setIn(1, 1, 16'h0, 32'd7, 2'b00, 0, 0, 0, 0);
    step();
    setIn(1, 1, 16'h0, 32'd8, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_val", 64'(alu_val_b), 64'd7);
      check("t4_hold_rdy", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("t4_rdy_pass", 64'(in_ready), 64'd1);
    step();
    check("t4_pass_val", 64'(alu_val_b), 64'd8);
    check("t4_pass_valid", 64'(out_valid), 64'd1);

    // 5: accept with flush in the same cycle
    setIn(1, 0, 16'h0055, 32'h0, 2'b00, 0, 0, 1, 1);
    step();
    check("t5_flush_valid", 64'(out_valid), 64'd0);
    check("t5_flush_data", 64'(alu_val_b), 64'd8);

    // 6: async reset between edges while holding
    setIn(1, 0, 16'h0123, 32'h0, 2'b00, 0, 0, 0, 0);
    step();
    check("t6_loaded", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(alu_val_b), 64'd0);
    rst_n = 1'b1;
    #1;
    check("t6_rel_ready", 64'(in_ready), 64'd1);
    step();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] off;
      case ($urandom_range(0, 5))
        0: off = 16'h0000;
        1: off = 16'h7FFF;
        2: off = 16'h8000;
        3: off = 16'hFFFF;
        default: off = 16'($urandom);
      endcase
      setIn($urandom_range(0, 3) != 0, 1'($urandom), off, $urandom, 2'($urandom),
            $urandom, $urandom, 1'($urandom), $urandom_range(0, 15) == 0);
      step();
    end

    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
